mem_bus_arbiter: RTL

//  Shares the single 64-bit memory port between two bus masters: m0 (cpu fetch/store path) and m1 (loader/debug).

---
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one 64-bit memory port between two masters. m0 is the cpu
//   fetch/store path and m1 is the loader/debug path. Each access is a
//   req/ack transaction. The winner's address, data and rw are latched on
//   grant. They are held on the memory port for MEM_LAT cycles, and the owner
//   then gets a one-cycle ack.
//
//   Optional feature macro: ARB_ROUND_ROBIN_EN
//     defined   : round-robin on ties; the master that was not last granted wins.
//     undefined : fixed priority, m0 over m1.
//
// Ports
//   clock, reset             single clock; synchronous active-high reset
//   m0_req/addr/wdata/rw     master 0 request (rw: 1 = read, 0 = write)
//   m0_ack                   master 0 completion pulse
//   m1_*                     same for master 1
//   rdata                    read data, valid in the ack cycle (0 for writes)
//   mem_en/addr/wdata/rw     memory port, active only in ACCESS
//   mem_rdata                memory read data, valid in every read mem_en cycle
//   busy                     high in ACCESS and RESP
//   owner                    master of the current/last transaction
module mem_bus_arbiter #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic              m0_rw,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic              m1_rw,
    output logic              m1_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rw,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              owner
);

    generate
        if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_bad_lat
            $error("mem_bus_arbiter: MEM_LAT must be in 1..15");
        end
    endgenerate

    localparam logic [3:0] CNT_INIT = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    state_t             r_state;
    logic [3:0]         r_cnt;
    logic               w_gnt_m1;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_rw;

`ifdef ARB_ROUND_ROBIN_EN
    // Resets to 1 so m0 wins the first tie after reset.
    logic r_last_owner;
    assign w_gnt_m1 = m1_req & (~m0_req | ~r_last_owner);
`else
    assign w_gnt_m1 = m1_req & ~m0_req;
`endif

    assign w_addr  = w_gnt_m1 ? m1_addr  : m0_addr;
    assign w_wdata = w_gnt_m1 ? m1_wdata : m0_wdata;
    assign w_rw    = w_gnt_m1 ? m1_rw    : m0_rw;

    // The mem_* outputs hold the latched request for the whole transaction.
    // No separate copy of the request is kept.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            rdata     <= '0;
            mem_en    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rw    <= 1'b1;
            busy      <= 1'b0;
            owner     <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_owner <= 1'b1;
`endif
        end else begin
            m0_ack <= 1'b0;
            m1_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (m0_req || m1_req) begin
                        r_state   <= S_ACCESS;
                        r_cnt     <= CNT_INIT;
                        owner     <= w_gnt_m1;
                        busy      <= 1'b1;
                        mem_en    <= 1'b1;
                        mem_addr  <= w_addr;
                        mem_wdata <= w_wdata;
                        mem_rw    <= w_rw;
`ifdef ARB_ROUND_ROBIN_EN
                        r_last_owner <= w_gnt_m1;
`endif
                    end
                end
                S_ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        rdata     <= mem_rw ? mem_rdata : '0;
                        r_state   <= S_RESP;
                        mem_en    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_rw    <= 1'b1;
                        // The ack is raised for the RESP cycle only; the default above clears it.
                        if (owner) m1_ack <= 1'b1;
                        else       m0_ack <= 1'b1;
                    end
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
